timer_irq_ctrl: RTL and testbench



---
 rtl/timer_irq_ctrl.sv | 152 +++++++++++++++
 tb/tb_timer_irq_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// NUM_CH auto-reload timers with a fixed-priority interrupt line to the core.
// Define TIMER_PRESCALE_EN to add an 8-bit per-channel prescaler (PSC at +12).
module timer_irq_ctrl #(
   parameter int          NUM_CH    = 4,
   parameter int          WIDTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   input  logic        irq_mask,
   output logic        irqout,
   output logic [2:0]  irq_id
);
   localparam logic [WIDTH-1:0] TL_MAX = '1;
   localparam logic [WIDTH-1:0] ONE    = 1;

   logic [WIDTH-1:0]  th [NUM_CH];
   logic [WIDTH-1:0]  tl [NUM_CH];
   logic [NUM_CH-1:0] en, ie, pend, pe;
   logic [NUM_CH-1:0] sel, wr_th, wr_tl, wr_tc, inc, wrap;
   logic [31:0]       off;
   logic              aligned, hit_vec, hit_pall, irq_any;
   logic [2:0]        id_nxt;
`ifdef TIMER_PRESCALE_EN
   logic [7:0]        psc  [NUM_CH];
   logic [7:0]        pcnt [NUM_CH];
   logic [NUM_CH-1:0] wr_psc;
`endif

   assign off      = addr - BASE_ADDR;
   assign aligned  = off[1:0] == 2'b00;
   assign hit_vec  = off == 32'h100;
   assign hit_pall = off == 32'h104;
   assign pe       = pend & ie;

   always_comb begin
      sel   = '0;
      wr_th = '0;
      wr_tl = '0;
      wr_tc = '0;
      inc   = '0;
      wrap  = '0;
`ifdef TIMER_PRESCALE_EN
      wr_psc = '0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         sel[c]   = aligned && off[31:4] == 28'(c);
         wr_th[c] = mem_write && sel[c] && off[3:2] == 2'd0;
         wr_tl[c] = mem_write && sel[c] && off[3:2] == 2'd1;
         wr_tc[c] = mem_write && sel[c] && off[3:2] == 2'd2;
         wrap[c]  = tl[c] == TL_MAX;
`ifdef TIMER_PRESCALE_EN
         wr_psc[c] = mem_write && sel[c] && off[3:2] == 2'd3;
         inc[c]    = en[c] && pcnt[c] == psc[c];
`else
         inc[c]    = en[c];
`endif
      end
   end

   // CPU writes are ordered after the count update so they win on TL/TH
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         en   <= '0;
         ie   <= '0;
         pend <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            th[c] <= '0;
            tl[c] <= '0;
`ifdef TIMER_PRESCALE_EN
            psc[c]  <= '0;
            pcnt[c] <= '0;
`endif
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (inc[c])
               tl[c] <= wrap[c] ? th[c] : tl[c] + ONE;
            if (wr_tl[c])
               tl[c] <= wdata[WIDTH-1:0];
            if (wr_th[c])
               th[c] <= wdata[WIDTH-1:0];
            if (wr_tc[c]) begin
               en[c] <= wdata[0];
               ie[c] <= wdata[1];
            end
            if (inc[c] && wrap[c])
               pend[c] <= 1'b1;
            else if (wr_tc[c] && wdata[2])
               pend[c] <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            if (wr_psc[c])
               psc[c] <= wdata[7:0];
            if (!en[c] || wr_tl[c] || wr_psc[c] || inc[c])
               pcnt[c] <= '0;
            else
               pcnt[c] <= pcnt[c] + 8'd1;
`endif
         end
      end
   end

   always_comb begin
      id_nxt = '0;
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (pe[c])
            id_nxt = 3'(c);
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         irqout  <= 1'b0;
         irq_id  <= '0;
         irq_any <= 1'b0;
      end else begin
         irqout  <= |pe & ~irq_mask;
         irq_id  <= id_nxt;
         irq_any <= |pe;
      end
   end

   always_comb begin
      rdata = '0;
      if (mem_read) begin
         unique case (1'b1)
            hit_vec:  rdata = {irq_any, 28'd0, irq_id};
            hit_pall: rdata = 32'(pend);
            default: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (sel[c]) begin
                     case (off[3:2])
                        2'd0:    rdata = 32'(th[c]);
                        2'd1:    rdata = 32'(tl[c]);
                        2'd2:    rdata = {29'd0, pend[c], ie[c], en[c]};
`ifdef TIMER_PRESCALE_EN
                        default: rdata = {24'd0, psc[c]};
`else
                        default: rdata = '0;
`endif
                     endcase
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: register table, directed corner cases,
// then random bus traffic against a behavioural model.
module tb_timer_irq_ctrl;
   localparam int          NUM_CH = 4;
   localparam int          WIDTH  = 32;
   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam logic [31:0] MASK   = 32'((64'd1 << WIDTH) - 64'd1);

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] rdata;
   logic        irq_mask = 1'b0;
   logic        irqout;
   logic [2:0]  irq_id;

   timer_irq_ctrl #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset_b(reset_b), .addr(addr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
      .irq_mask(irq_mask), .irqout(irqout), .irq_id(irq_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0]       th_m [NUM_CH];
   logic [31:0]       tl_m [NUM_CH];
   logic [NUM_CH-1:0] en_m, ie_m, pend_m;
   logic              irq_m, any_m;
   int                id_m;
`ifdef TIMER_PRESCALE_EN
   logic [7:0]        psc_m  [NUM_CH];
   int                div_m  [NUM_CH];
`endif

   typedef struct {
      logic        is_wr;
      logic [31:0] a;
      logic [31:0] d;
      string       name;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ra(input int c, input int r);
      return BASE + 32'(16 * c + 4 * r);
   endfunction

   // Model: spec rules applied to the state seen just before each edge
   task automatic model_step();
      logic [NUM_CH-1:0] pe;
      logic [31:0] off;
      int wc, wreg;
      bit tk, setp;
      if (!reset_b) begin
         for (int c = 0; c < NUM_CH; c++) begin
            th_m[c] = '0;
            tl_m[c] = '0;
`ifdef TIMER_PRESCALE_EN
            psc_m[c] = '0;
            div_m[c] = 0;
`endif
         end
         en_m = '0; ie_m = '0; pend_m = '0;
         irq_m = 1'b0; any_m = 1'b0; id_m = 0;
         return;
      end
      pe    = pend_m & ie_m;
      any_m = |pe;
      irq_m = any_m && !irq_mask;
      id_m  = 0;
      for (int c = NUM_CH - 1; c >= 0; c--)
         if (pe[c]) id_m = c;
      wc = -1; wreg = -1;
      off = addr - BASE;
      if (mem_write && off[1:0] == 2'b00 && off < 32'(16 * NUM_CH)) begin
         wc   = int'(off / 16);
         wreg = int'(off % 16) / 4;
      end
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef TIMER_PRESCALE_EN
         tk = en_m[c] && (div_m[c] == int'(psc_m[c]));
         if (!en_m[c] || tk || (wc == c && (wreg == 1 || wreg == 3)))
            div_m[c] = 0;
         else
            div_m[c] = div_m[c] + 1;
`else
         tk = en_m[c];
`endif
         setp = tk && (tl_m[c] == MASK);
         if (tk)
            tl_m[c] = setp ? th_m[c] : ((tl_m[c] + 1) & MASK);
         if (setp)
            pend_m[c] = 1'b1;
         if (wc == c) begin
            case (wreg)
               0: th_m[c] = wdata & MASK;
               1: tl_m[c] = wdata & MASK;
               2: begin
                  en_m[c] = wdata[0];
                  ie_m[c] = wdata[1];
                  if (wdata[2] && !setp) pend_m[c] = 1'b0;
               end
               default: begin
`ifdef TIMER_PRESCALE_EN
                  psc_m[c] = wdata[7:0];
`endif
               end
            endcase
         end
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      logic [31:0] off;
      int c, r;
      off = a - BASE;
      if (off[1:0] != 2'b00) return '0;
      if (off == 32'h100) return {any_m, 28'd0, 3'(id_m)};
      if (off == 32'h104) return 32'(pend_m);
      if (off >= 32'(16 * NUM_CH)) return '0;
      c = int'(off / 16);
      r = int'(off % 16) / 4;
      case (r)
         0: return th_m[c];
         1: return tl_m[c];
         2: return {29'd0, pend_m[c], ie_m[c], en_m[c]};
`ifdef TIMER_PRESCALE_EN
         default: return {24'd0, psc_m[c]};
`else
         default: return '0;
`endif
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("irqout", 32'(irqout), 32'(irq_m));
      check("irq_id", 32'(irq_id), 32'(id_m));
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a; mem_read = 1'b1;
      #1;
      d = rdata;
      mem_read = 1'b0;
   endtask

   logic [31:0] d;

   initial begin
      tbl.push_back('{1'b1, ra(2, 0), 32'h1234_5678, "th_wr"});
      tbl.push_back('{1'b0, ra(2, 0), 32'h1234_5678, "th_rd"});
      tbl.push_back('{1'b1, ra(2, 1), 32'hDEAD_BEEF, "tl_wr"});
      tbl.push_back('{1'b0, ra(2, 1), 32'hDEAD_BEEF, "tl_frozen"});
      tbl.push_back('{1'b1, ra(2, 2), 32'h4, "pend_wr"});
      tbl.push_back('{1'b0, ra(2, 2), 32'h0, "pend_no_set"});
      tbl.push_back('{1'b1, ra(2, 2), 32'h2, "tcon_wr"});
      tbl.push_back('{1'b0, ra(2, 2), 32'h2, "tcon_ie"});
      tbl.push_back('{1'b1, ra(2, 2), 32'h0, "tcon_off"});
      tbl.push_back('{1'b0, BASE + 32'hC, 32'h0, "off12_rst"});
      tbl.push_back('{1'b1, BASE + 32'h40, 32'hFFFF_FFFF, "oob_wr"});
      tbl.push_back('{1'b0, BASE + 32'h40, 32'h0, "ch_oob"});
      tbl.push_back('{1'b1, BASE + 32'h26, 32'h0, "unal_wr"});
      tbl.push_back('{1'b0, ra(2, 1), 32'hDEAD_BEEF, "unaligned_wr"});
      tbl.push_back('{1'b0, BASE + 32'h25, 32'h0, "unaligned_rd"});
      tbl.push_back('{1'b0, BASE + 32'h108, 32'h0, "glob_unmapped"});
      tbl.push_back('{1'b0, BASE + 32'h100, 32'h0, "irq_vec_idle"});
      tbl.push_back('{1'b0, BASE + 32'h104, 32'h0, "pend_all_idle"});
      tbl.push_back('{1'b0, BASE - 32'h4, 32'h0, "below_base"});
      tbl.push_back('{1'b1, BASE + 32'h100, 32'hFFFF_FFFF, "vec_wr"});
      tbl.push_back('{1'b0, BASE + 32'h100, 32'h0, "irq_vec_ro"});

      reset_b = 1'b0;
      tick();
      tick();
      reset_b = 1'b1;
      tick();
      check("rst_irqout", 32'(irqout), 32'h0);
      check("rst_irq_id", 32'(irq_id), 32'h0);

      foreach (tbl[i]) begin
         if (tbl[i].is_wr) begin
            wr(tbl[i].a, tbl[i].d);
         end else begin
            rd(tbl[i].a, d);
            check(tbl[i].name, d, tbl[i].d);
            tick();
         end
      end
      addr = ra(2, 0); mem_read = 1'b0;
      #1;
      check("rd_strobe_low", rdata, 32'h0);

      // period and reload
      wr(ra(0, 0), 32'hFFFF_FFF0);
      wr(ra(0, 1), 32'hFFFF_FFF0);
      wr(ra(0, 2), 32'h3);
      repeat (15) tick();
      rd(ra(0, 1), d); check("period_tl_max", d, 32'hFFFF_FFFF);
      rd(ra(0, 2), d); check("period_pend0", d, 32'h3);
      tick();
      rd(ra(0, 2), d); check("period_pend1", d, 32'h7);
      rd(ra(0, 1), d); check("period_reload", d, 32'hFFFF_FFF0);
      check("period_irq_lag", 32'(irqout), 32'h0);
      tick();
      check("period_irq", 32'(irqout), 32'h1);
      rd(BASE + 32'h100, d); check("period_vec", d, 32'h8000_0000);

      // same-edge collisions on ch0
      wr(ra(0, 2), 32'h7);
      rd(ra(0, 2), d); check("w1c_clear", d, 32'h3);
      wr(ra(0, 1), 32'hFFFF_FFFF);
      wr(ra(0, 2), 32'h7);
      rd(ra(0, 2), d); check("w1c_vs_set", d, 32'h7);
      rd(ra(0, 1), d); check("w1c_reload", d, 32'hFFFF_FFF0);
      wr(ra(0, 2), 32'h7);
      wr(ra(0, 1), 32'hFFFF_FFFF);
      wr(ra(0, 1), 32'h5);
      rd(ra(0, 1), d); check("tl_wr_wins", d, 32'h5);
      rd(ra(0, 2), d); check("tl_wr_pend", d, 32'h7);
      wr(ra(0, 1), 32'hFFFF_FFFF);
      wr(ra(0, 0), 32'h100);
      rd(ra(0, 1), d); check("th_old", d, 32'hFFFF_FFF0);
      wr(ra(0, 1), 32'hFFFF_FFFF);
      tick();
      rd(ra(0, 1), d); check("th_new", d, 32'h100);
      wr(ra(0, 2), 32'h4);
      rd(ra(0, 2), d); check("ch0_stop", d, 32'h0);

      // priority ch1 vs ch3
      wr(ra(1, 1), 32'hFFFF_FFFF);
      wr(ra(3, 1), 32'hFFFF_FFFF);
      wr(ra(1, 2), 32'h3);
      wr(ra(3, 2), 32'h3);
      wr(ra(1, 2), 32'h2);
      wr(ra(3, 2), 32'h2);
      tick();
      check("prio_id1", 32'(irq_id), 32'h1);
      rd(BASE + 32'h104, d); check("prio_pend_all", d, 32'hA);
      wr(ra(1, 2), 32'h7);
      check("prio_lag", 32'(irq_id), 32'h1);
      tick();
      check("prio_id3", 32'(irq_id), 32'h3);
      wr(ra(3, 2), 32'h6);
      tick();
      check("prio_none", 32'(irqout), 32'h0);
      wr(ra(1, 2), 32'h0);

      // masking and IE gating on ch2
      irq_mask = 1'b1;
      wr(ra(2, 1), 32'hFFFF_FFFF);
      wr(ra(2, 2), 32'h3);
      wr(ra(2, 2), 32'h2);
      tick();
      tick();
      check("mask_hold", 32'(irqout), 32'h0);
      irq_mask = 1'b0;
      tick();
      check("mask_drop", 32'(irqout), 32'h1);
      wr(ra(2, 2), 32'h0);
      tick();
      check("ie_off", 32'(irqout), 32'h0);
      rd(BASE + 32'h104, d); check("ie_off_pend", d, 32'h4);

`ifdef TIMER_PRESCALE_EN
      wr(ra(0, 3), 32'h3);
      wr(ra(0, 0), 32'hFFFF_FFFE);
      wr(ra(0, 1), 32'hFFFF_FFFE);
      wr(ra(0, 2), 32'h3);
      repeat (3) tick();
      rd(ra(0, 1), d); check("psc_hold", d, 32'hFFFF_FFFE);
      tick();
      rd(ra(0, 1), d); check("psc_step", d, 32'hFFFF_FFFF);
      repeat (3) tick();
      rd(ra(0, 2), d); check("psc_pend0", d, 32'h3);
      tick();
      rd(ra(0, 2), d); check("psc_pend1", d, 32'h7);
      rd(ra(0, 1), d); check("psc_reload", d, 32'hFFFF_FFFE);
      wr(ra(0, 2), 32'h4);
`else
      wr(ra(0, 3), 32'hFF);
      rd(ra(0, 3), d); check("off12_unmapped", d, 32'h0);
`endif

      // reset while counting
      wr(ra(0, 1), 32'hFFFF_FFF0);
      wr(ra(0, 2), 32'h3);
      repeat (5) tick();
      reset_b = 1'b0;
      tick();
      tick();
      check("rst2_irqout", 32'(irqout), 32'h0);
      check("rst2_irq_id", 32'(irq_id), 32'h0);
      reset_b = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         tick();
         for (int r = 0; r < 3; r++) begin
            rd(ra(c, r), d);
            check("rst2_reg", d, 32'h0);
         end
      end
      repeat (20) tick();
      rd(BASE + 32'h100, d); check("rst2_vec", d, 32'h0);
      rd(BASE + 32'h104, d); check("rst2_pend", d, 32'h0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int op, c;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         c  = $urandom_range(0, NUM_CH - 1);
         irq_mask = ($urandom_range(0, 7) == 0);
         if (op < 2)
            wr(ra(c, 1), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         else if (op == 2)
            wr(ra(c, 0), $urandom_range(0, 1) ? $urandom
                         : 32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
         else if (op == 3)
            wr(ra(c, 2), 32'($urandom_range(0, 7)));
         else if (op == 4)
            wr(BASE + 32'($urandom_range(0, 32'h10F)), $urandom);
         else if (op < 8) begin
            a = BASE + 32'($urandom_range(0, 32'h10F));
            rd(a, d);
            check("rand_rd", d, exp_rd(a));
            tick();
         end else
            tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
